// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, sync and blank generation, and a
// two-stage aligned DAC output. Optional solid white frame border via VGA_BORDER_EN.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        iVGA_CLK,
  input  logic        reset_n,
  input  logic [15:0] iRGB,
  output logic [9:0]  oVGA_X,
  output logic [9:0]  oVGA_Y,
  output logic [4:0]  oVGA_R,
  output logic [5:0]  oVGA_G,
  output logic [4:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N,
  output logic        oVblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [9:0]  hCnt, vCnt;
  logic        hActive, vActive, active, hsRaw, vsRaw;
  logic        d1Active, d1Hs, d1Vs;
  logic [15:0] pixel, rgbOut;

  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (hCnt == H_LAST) begin
      hCnt <= '0;
      vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 10'd1;
    end else begin
      hCnt <= hCnt + 10'd1;
    end
  end

  assign hActive = hCnt < H_ACT;
  assign vActive = vCnt < V_ACT;
  assign active  = hActive && vActive;
  assign hsRaw   = !((hCnt >= H_SYNC_BEG) && (hCnt <= H_SYNC_END));
  assign vsRaw   = !((vCnt >= V_SYNC_BEG) && (vCnt <= V_SYNC_END));

  // Drawing stage sees coordinates straight off the counters; its colour returns a clock later.
  assign oVGA_X        = hActive ? hCnt : '0;
  assign oVGA_Y        = vActive ? vCnt : '0;
  assign oVblank_start = (hCnt == '0) && (vCnt == V_ACT);

`ifdef VGA_BORDER_EN
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

  logic borderRaw, d1Border;

  assign borderRaw = active && ((hCnt == '0) || (hCnt == H_ACT_LAST) ||
                                (vCnt == '0) || (vCnt == V_ACT_LAST));

  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) d1Border <= 1'b0;
    else          d1Border <= borderRaw;
  end

  assign pixel = d1Border ? 16'hFFFF : iRGB;
`else
  assign pixel = iRGB;
`endif

  // d1 aligns timing flags with iRGB; the output stage registers all DAC pins together.
  always_ff @(posedge iVGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      d1Active     <= 1'b0;
      d1Hs         <= 1'b1;
      d1Vs         <= 1'b1;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_N <= 1'b0;
      rgbOut       <= '0;
    end else begin
      d1Active     <= active;
      d1Hs         <= hsRaw;
      d1Vs         <= vsRaw;
      oVGA_HS      <= d1Hs;
      oVGA_VS      <= d1Vs;
      oVGA_BLANK_N <= d1Active;
      rgbOut       <= d1Active ? pixel : '0;
    end
  end

  assign {oVGA_R, oVGA_G, oVGA_B} = rgbOut;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing using a shrunken raster; a position-arithmetic model
// predicts every cycle's pins and a posedge+1 monitor compares them.
module tb_vga_timing;

  localparam int HA = 16, HF = 4, HSW = 6, HB = 4;
  localparam int VA = 12, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] iRGB;
  logic [9:0]  oVGA_X, oVGA_Y;
  logic [4:0]  oVGA_R, oVGA_B;
  logic [5:0]  oVGA_G;
  logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVblank_start;

  vga_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
  ) dut (
    .iVGA_CLK(clk), .reset_n(reset_n), .iRGB(iRGB),
    .oVGA_X(oVGA_X), .oVGA_Y(oVGA_Y),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
    .oVblank_start(oVblank_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] col;
    logic        hs, vs, bl;
    logic [9:0]  x, y;
    logic        vb;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   vbCnt  = 0;
  int   rgbMode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Expected pins for a raster position derived only from the timing rules.
  function automatic exp_t model(input int dacPos, input logic dacValid,
                                 input logic [15:0] rgb, input int xyPos);
    exp_t e;
    int h, v, hn, vn;
    logic act, border;
    h = dacPos % HT;
    v = dacPos / HT;
    act = (h < HA) && (v < VA);
    border = (h == 0) || (h == HA - 1) || (v == 0) || (v == VA - 1);
    e.hs = !dacValid || !((h >= HA + HF) && (h < HA + HF + HSW));
    e.vs = !dacValid || !((v >= VA + VF) && (v < VA + VF + VSW));
    e.bl = dacValid && act;
`ifdef VGA_BORDER_EN
    e.col = !e.bl ? 16'h0 : (border ? 16'hFFFF : rgb);
`else
    e.col = !e.bl ? 16'h0 : rgb;
`endif
    hn = xyPos % HT;
    vn = xyPos / HT;
    e.x  = (hn < HA) ? 10'(hn) : 10'd0;
    e.y  = (vn < VA) ? 10'(vn) : 10'd0;
    e.vb = (hn == 0) && (vn == VA);
    return e;
  endfunction

  // Caller is at the negedge where reset_n was just released: counters sit at position 0.
  task automatic runCycles(input int n);
    logic [15:0] rgb;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      case (rgbMode)
        1:       rgb = 16'h1234;
        2:       rgb = 16'hFFFF;
        default: rgb = 16'($urandom);
      endcase
      iRGB = rgb;
      if (k == 0) q.push_back(model(0, 1'b0, rgb, 1));
      else        q.push_back(model((k - 1) % FT, 1'b1, rgb, (k + 1) % FT));
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dac", {oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B},
                 {e.hs, e.vs, e.bl, e.col});
      chk("xy", {oVGA_X, oVGA_Y}, {e.x, e.y});
      chk("vblank", oVblank_start, e.vb);
      if (oVblank_start) vbCnt++;
    end
  end

  task automatic checkReset(input string tag);
    chk({tag, "_dac"}, {oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_R, oVGA_G, oVGA_B},
                       {1'b1, 1'b1, 1'b0, 16'h0});
    chk({tag, "_xyvb"}, {oVGA_X, oVGA_Y, oVblank_start}, 21'h0);
  endtask

  // Asserts reset asynchronously mid-line, holds it three clocks, releases at a negedge.
  task automatic doReset(input string tag);
    @(posedge clk);
    #3;
    chk({tag, "_drained"}, 64'(q.size()), 64'd0);
    reset_n = 1'b0;
    #1;
    checkReset(tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset({tag, "_held"});
    reset_n = 1'b1;
    vbCnt = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    iRGB    = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("por");
    @(negedge clk);
    reset_n = 1'b1;

    rgbMode = 0;
    runCycles(FT * 3);
    @(posedge clk);
    #2;
    chk("vblank_pulses_3frames", 64'(vbCnt), 64'd3);

    // Reset lands while the output shows a visible pixel with known colour.
    doReset("rst_visible");
    rgbMode = 1;
    runCycles(5 * HT + 10 + 2);

    // Reset lands while both syncs are asserted on the pins.
    doReset("rst_sync");
    rgbMode = 2;
    runCycles((VA + VF) * HT + HA + HF + 1 + 2);

    doReset("rst_blank");
    rgbMode = 0;
    runCycles(FT + HT * 3 + 7);
    @(posedge clk);
    #2;
    chk("vblank_pulses_final", 64'(vbCnt), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
